nic_ager_mc: RTL

Multi-channel, parametrised packet ager for the NIC ring, one stage per node on the ring path. It ages every valid packet on NCH request channels, the retry channel and the interrupt channel. It also removes expired and stale broadcast packets. It turns stalled requests into PT_RETRY packets, buffers them in a small queue, and injects them into empty retry-channel slots. It also keeps saturating statistics counters.

---
 rtl/nic_ager_mc_pkg.sv | 42 ++++
 rtl/nic_ager_mc_if.sv | 25 ++
 rtl/nic_ager_mc_retry_fifo.sv | 58 +++++
 rtl/nic_ager_mc.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/nic_ager_mc_pkg.sv
// Shared packet types, ring constants and small helpers for the NIC ring ager.
package nic_pkg;

  localparam logic [5:0] NIC_BCAST_DID = 6'd63;

  typedef enum logic [1:0] {
    PT_REQ   = 2'd0,
    PT_RESP  = 2'd1,
    PT_RETRY = 2'd2,
    PT_IRQ   = 2'd3
  } pkt_type_e;

  typedef struct packed {
    logic [5:0]  sid;
    logic [5:0]  did;
    pkt_type_e   typ;
    logic [3:0]  age;
    logic [15:0] data;
  } packet_t;

  typedef struct packed {
    logic [5:0] sid;
    logic [5:0] did;
    logic [3:0] age;
    logic [7:0] vec;
  } ipacket_t;

  function automatic logic nic_valid(input logic [5:0] sid, input logic [5:0] did);
    return (sid | did) != 6'd0;
  endfunction

  function automatic logic [3:0] age_inc(input logic [3:0] age);
    return (age == 4'hF) ? age : age + 4'd1;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [3:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {13'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/nic_ager_mc_if.sv
// Ring-side bundle of the ager: request, retry and interrupt channels plus status.
// Slot semantics: a slot is valid when sid|did != 0; there is no backpressure, every slot advances each cycle.
interface nic_ager_mc_if #(parameter int NCH = 2);

  nic_pkg::packet_t [NCH-1:0] packet_i;
  nic_pkg::packet_t [NCH-1:0] packet_o;
  nic_pkg::packet_t           rpacket_i;
  nic_pkg::packet_t           rpacket_o;
  nic_pkg::ipacket_t          ipacket_i;
  nic_pkg::ipacket_t          ipacket_o;
  logic                       rq_full_o;
  logic [15:0]                stat_expired_o;
  logic [15:0]                stat_rdrop_o;

  modport master (
    output packet_i, rpacket_i, ipacket_i,
    input  packet_o, rpacket_o, ipacket_o, rq_full_o, stat_expired_o, stat_rdrop_o
  );

  modport slave (
    input  packet_i, rpacket_i, ipacket_i,
    output packet_o, rpacket_o, ipacket_o, rq_full_o, stat_expired_o, stat_rdrop_o
  );

endinterface

// File: rtl/nic_ager_mc_retry_fifo.sv
// Small synchronous FIFO holding generated retry packets until a free retry slot appears.
module nic_retry_fifo
  import nic_pkg::*;
#(
  parameter int RQ_DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push,
  input  logic    pop,
  input  packet_t din,
  output packet_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(RQ_DEPTH);
  localparam int CW = $clog2(RQ_DEPTH + 1);

  packet_t         mem [RQ_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop)      count_n = count + CW'(1);
    else if (!do_push && do_pop) count_n = count - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // full is registered from the post-update occupancy so it is clean at the port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
      full  <= (count_n == CW'(RQ_DEPTH));
    end
  end

endmodule

// File: rtl/nic_ager_mc.sv
// Per-node ring ager: ages and expires packets, turns stalled requests into retries,
// injects queued retries into empty retry slots and keeps saturating drop statistics.
module nic_ager_mc
  import nic_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int RETRY_AGE  = 7,
  parameter int EXPIRE_AGE = 15,
  parameter int BCAST_AGE  = 3,
  parameter int RQ_DEPTH   = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  nic_ager_mc_if.slave bus
);

  packet_t [NCH-1:0] pkt_n;
  packet_t [NCH-1:0] pkt_q;
  logic    [NCH-1:0] qual;
  logic    [NCH-1:0] exp_ch;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    packet_t p_in;
    packet_t p_nxt;
    logic    q_c;
    logic    e_c;

    assign p_in = bus.packet_i[c];

    always_comb begin
      p_nxt = '0;
      q_c   = 1'b0;
      e_c   = 1'b0;
      if (nic_valid(p_in.sid, p_in.did)) begin
        q_c = (int'(p_in.age) == RETRY_AGE);
        if (int'(p_in.age) >= EXPIRE_AGE) begin
          e_c = 1'b1;
        end else begin
          p_nxt     = p_in;
          p_nxt.age = age_inc(p_in.age);
        end
      end
    end

    assign pkt_n[c]  = p_nxt;
    assign qual[c]   = q_c;
    assign exp_ch[c] = e_c;
  end

  logic       sel_found;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  packet_t    rq_entry;
  packet_t    rq_head;
  logic [3:0] n_qual;
  logic [3:0] n_drop;
  logic [3:0] n_exp;

  // Lowest qualifying channel owns the single push; the rest are counted as drops
  always_comb begin
    sel_found = 1'b0;
    rq_entry  = '0;
    n_qual    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (qual[c]) begin
        n_qual = n_qual + 4'd1;
        if (!sel_found) begin
          sel_found    = 1'b1;
          rq_entry     = bus.packet_i[c];
          rq_entry.sid = bus.packet_i[c].did;
          rq_entry.did = bus.packet_i[c].sid;
          rq_entry.typ = PT_RETRY;
          rq_entry.age = '0;
        end
      end
    end
  end

  assign push   = sel_found && !full;
  assign n_drop = n_qual - {3'd0, push};

  packet_t  rp_n;
  ipacket_t ip_n;
  logic     exp_r;
  logic     exp_i;

  always_comb begin
    rp_n  = '0;
    exp_r = 1'b0;
    pop   = 1'b0;
    if (!nic_valid(bus.rpacket_i.sid, bus.rpacket_i.did)) begin
      if (!empty) begin
        pop  = 1'b1;
        rp_n = rq_head;
      end
    end else if (int'(bus.rpacket_i.age) >= EXPIRE_AGE) begin
      exp_r = 1'b1;
    end else begin
      rp_n     = bus.rpacket_i;
      rp_n.age = age_inc(bus.rpacket_i.age);
    end
  end

  always_comb begin
    ip_n  = '0;
    exp_i = 1'b0;
    if (nic_valid(bus.ipacket_i.sid, bus.ipacket_i.did)) begin
      if (int'(bus.ipacket_i.age) >= EXPIRE_AGE ||
          (bus.ipacket_i.did == NIC_BCAST_DID && int'(bus.ipacket_i.age) > BCAST_AGE)) begin
        exp_i = 1'b1;
      end else begin
        ip_n     = bus.ipacket_i;
        ip_n.age = age_inc(bus.ipacket_i.age);
      end
    end
  end

  always_comb begin
    n_exp = {3'd0, exp_r} + {3'd0, exp_i};
    for (int c = 0; c < NCH; c++) n_exp = n_exp + {3'd0, exp_ch[c]};
  end

  nic_retry_fifo #(.RQ_DEPTH(RQ_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .din    (rq_entry),
    .head   (rq_head),
    .full   (full),
    .empty  (empty)
  );

  packet_t     rp_q;
  ipacket_t    ip_q;
  logic [15:0] stat_exp_q;
  logic [15:0] stat_rdrop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_q        <= '0;
      rp_q         <= '0;
      ip_q         <= '0;
      stat_exp_q   <= '0;
      stat_rdrop_q <= '0;
    end else begin
      pkt_q        <= pkt_n;
      rp_q         <= rp_n;
      ip_q         <= ip_n;
      stat_exp_q   <= sat_add16(stat_exp_q, n_exp);
      stat_rdrop_q <= sat_add16(stat_rdrop_q, n_drop);
    end
  end

  assign bus.packet_o       = pkt_q;
  assign bus.rpacket_o      = rp_q;
  assign bus.ipacket_o      = ip_q;
  assign bus.rq_full_o      = full;
  assign bus.stat_expired_o = stat_exp_q;
  assign bus.stat_rdrop_o   = stat_rdrop_q;

endmodule
